// File: rtl/vp_pkg.sv
// Shared types and default 1280x720 timing for the video-process output stage.
package vp_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    VBLK  = 3'd1,
    HWAIT = 3'd2,
    ACT   = 3'd3,
    HBLK  = 3'd4
  } vp_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  localparam int unsigned VP_H_DISP   = 1280;
  localparam int unsigned VP_V_DISP   = 720;
  localparam int unsigned VP_H_BLANK  = 370;
  localparam int unsigned VP_V_BLANK  = 30;
  localparam int unsigned VP_VS_LINES = 5;
  localparam int unsigned VP_X_WIDTH  = 11;
  localparam int unsigned VP_Y_WIDTH  = 11;
  localparam int unsigned VP_FIFO_AW  = 11;

endpackage

// File: rtl/vp_sync_fifo.sv
// Single-clock line FIFO with registered read data (1-cycle latency) and synchronous flush.
module vp_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FIFO_AW    = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [FIFO_AW:0]      level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [2**FIFO_AW];
  logic [FIFO_AW-1:0]    wr_ptr;
  logic [FIFO_AW-1:0]    rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level == DEPTH);
  assign empty   = (level == '0);
  // Flush wins over any same-cycle push or pop.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/vp_frame_filler.sv
// Output stage: buffers a scaled image and regenerates a full raster with the image
// placed at (start_x, start_y) over a background colour, stalling per line on data shortage.
module vp_frame_filler
  import vp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = $bits(rgb888_t),
  parameter int unsigned H_DISP     = VP_H_DISP,
  parameter int unsigned V_DISP     = VP_V_DISP,
  parameter int unsigned H_BLANK    = VP_H_BLANK,
  parameter int unsigned V_BLANK    = VP_V_BLANK,
  parameter int unsigned VS_LINES   = VP_VS_LINES,
  parameter int unsigned X_WIDTH    = VP_X_WIDTH,
  parameter int unsigned Y_WIDTH    = VP_Y_WIDTH,
  parameter int unsigned FIFO_AW    = VP_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [X_WIDTH-1:0]    start_x,
  input  logic [Y_WIDTH-1:0]    start_y,
  input  logic [X_WIDTH-1:0]    img_w,
  input  logic [Y_WIDTH-1:0]    img_h,
  input  logic [DATA_WIDTH-1:0] bg_color,
  input  logic                  pre_vs,
  input  logic                  pre_de,
  input  logic [DATA_WIDTH-1:0] pre_data,
  output logic                  post_vs,
  output logic                  post_de,
  output logic [DATA_WIDTH-1:0] post_data,
  output logic                  overflow,
  output logic                  cfg_err
);

  localparam int unsigned LINE_LEN = H_DISP + H_BLANK;
  localparam int unsigned BW       = $clog2(LINE_LEN + 1);
  localparam int unsigned VW       = $clog2(V_BLANK + 1);

  localparam logic [X_WIDTH:0]   H_LIM     = (X_WIDTH+1)'(H_DISP);
  localparam logic [Y_WIDTH:0]   V_LIM     = (Y_WIDTH+1)'(V_DISP);
  localparam logic [X_WIDTH-1:0] X_LAST    = X_WIDTH'(H_DISP - 1);
  localparam logic [Y_WIDTH-1:0] Y_LAST    = Y_WIDTH'(V_DISP - 1);
  localparam logic [BW-1:0]      LINE_LAST = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0]      HBLK_LAST = BW'(H_BLANK - 1);
  localparam logic [VW-1:0]      VBLK_LAST = VW'(V_BLANK - 1);
  localparam logic [VW-1:0]      VS_END    = VW'(VS_LINES);

  logic                  pre_vs_d;
  logic                  fs;

  logic                  fill_en;
  logic [X_WIDTH-1:0]    lat_sx;
  logic [Y_WIDTH-1:0]    lat_sy;
  logic [X_WIDTH-1:0]    lat_w;
  logic [Y_WIDTH-1:0]    lat_h;
  logic [DATA_WIDTH-1:0] lat_bg;
  logic [X_WIDTH:0]      sum_x;
  logic [Y_WIDTH:0]      sum_y;

  vp_state_t             state;
  logic [X_WIDTH-1:0]    x;
  logic [Y_WIDTH-1:0]    y;
  logic [BW-1:0]         bcnt;
  logic [VW-1:0]         vcnt;

  logic                  fill_mode;
  logic                  bypass_now;
  logic                  img_row;
  logic                  img_col;
  logic                  line_ready;
  logic                  push_req;
  logic                  pop;

  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [FIFO_AW:0]      fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;

  logic                  s1_vs;
  logic                  s1_de;
  logic                  s1_sel;
  logic [DATA_WIDTH-1:0] s1_data;

  assign fs    = pre_vs && !pre_vs_d;
  assign sum_x = {1'b0, start_x} + {1'b0, img_w};
  assign sum_y = {1'b0, start_y} + {1'b0, img_h};

  assign fill_mode  = (state != IDLE) && fill_en;
  // At fs the freshly presented en decides the mode so bypass has no gap at the sync edge.
  assign bypass_now = fs ? !en : ((state != IDLE) && !fill_en);

  assign img_row    = !cfg_err && (y >= lat_sy) &&
                      ({1'b0, y} < ({1'b0, lat_sy} + {1'b0, lat_h}));
  assign img_col    = (x >= lat_sx) &&
                      ({1'b0, x} < ({1'b0, lat_sx} + {1'b0, lat_w}));
  assign line_ready = 32'(fifo_level) >= 32'(lat_w);

  assign push_req = pre_de && fill_mode && !fs;
  assign pop      = fill_mode && !fs && (state == ACT) && img_row && img_col && !fifo_empty;

  vp_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fs),
    .push  (push_req),
    .pop   (pop),
    .din   (pre_data),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_vs_d <= 1'b0;
      fill_en  <= 1'b0;
      lat_sx   <= '0;
      lat_sy   <= '0;
      lat_w    <= '0;
      lat_h    <= '0;
      lat_bg   <= '0;
      cfg_err  <= 1'b0;
    end else begin
      pre_vs_d <= pre_vs;
      if (fs) begin
        fill_en <= en;
        lat_sx  <= start_x;
        lat_sy  <= start_y;
        lat_w   <= img_w;
        lat_h   <= img_h;
        lat_bg  <= bg_color;
        cfg_err <= (sum_x > H_LIM) || (sum_y > V_LIM);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (fs) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // Raster FSM; in bypass it is parked in VBLK because fill_en gates all progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      bcnt  <= '0;
      vcnt  <= '0;
    end else if (fs) begin
      state <= VBLK;
      x     <= '0;
      y     <= '0;
      bcnt  <= '0;
      vcnt  <= '0;
    end else if (fill_en) begin
      case (state)
        VBLK: begin
          if (bcnt == LINE_LAST) begin
            bcnt <= '0;
            if (vcnt == VBLK_LAST) begin
              vcnt  <= '0;
              state <= HWAIT;
            end else begin
              vcnt <= vcnt + 1'b1;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        HWAIT: begin
          if (!img_row || line_ready) state <= ACT;
        end
        ACT: begin
          if (x == X_LAST) begin
            x     <= '0;
            state <= HBLK;
          end else begin
            x <= x + 1'b1;
          end
        end
        HBLK: begin
          if (bcnt == HBLK_LAST) begin
            bcnt <= '0;
            if (y == Y_LAST) begin
              y     <= '0;
              state <= VBLK;
            end else begin
              y     <= y + 1'b1;
              state <= HWAIT;
            end
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage 1 lines up with the FIFO read; stage 2 picks popped data or the stored pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_sel  <= 1'b0;
      s1_data <= '0;
    end else if (bypass_now) begin
      s1_vs   <= pre_vs;
      s1_de   <= pre_de;
      s1_sel  <= 1'b0;
      s1_data <= pre_data;
    end else if (fill_mode && !fs) begin
      s1_vs   <= (state == VBLK) && (vcnt < VS_END);
      s1_de   <= (state == ACT);
      s1_sel  <= pop;
      s1_data <= lat_bg;
    end else begin
      s1_vs   <= 1'b0;
      s1_de   <= 1'b0;
      s1_sel  <= 1'b0;
      s1_data <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vs   <= 1'b0;
      post_de   <= 1'b0;
      post_data <= '0;
    end else begin
      post_vs   <= s1_vs;
      post_de   <= s1_de;
      post_data <= s1_sel ? fifo_dout : s1_data;
    end
  end

endmodule

// File: tb/tb_vp_frame_filler.sv
// Randomised bench for vp_frame_filler on a small 8x4 raster with an 8-deep FIFO,
// checked against a per-pixel placement model of the expected output frame.
module tb_vp_frame_filler;

  localparam int HD    = 8;
  localparam int VD    = 4;
  localparam int HB    = 4;
  localparam int VB    = 3;
  localparam int VSL   = 1;
  localparam int XW    = 4;
  localparam int YW    = 4;
  localparam int AW    = 3;
  localparam int DW    = 24;
  localparam int DEPTH = 8;
  localparam int FR    = HD * VD;
  localparam int LINE  = HD + HB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [XW-1:0] start_x;
  logic [YW-1:0] start_y;
  logic [XW-1:0] img_w;
  logic [YW-1:0] img_h;
  logic [DW-1:0] bg_color;
  logic          pre_vs;
  logic          pre_de;
  logic [DW-1:0] pre_data;
  logic          post_vs;
  logic          post_de;
  logic [DW-1:0] post_data;
  logic          overflow;
  logic          cfg_err;

  always #5 clk = ~clk;

  vp_frame_filler #(
    .DATA_WIDTH (DW),
    .H_DISP     (HD),
    .V_DISP     (VD),
    .H_BLANK    (HB),
    .V_BLANK    (VB),
    .VS_LINES   (VSL),
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW),
    .FIFO_AW    (AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start_x   (start_x),
    .start_y   (start_y),
    .img_w     (img_w),
    .img_h     (img_h),
    .bg_color  (bg_color),
    .pre_vs    (pre_vs),
    .pre_de    (pre_de),
    .pre_data  (pre_data),
    .post_vs   (post_vs),
    .post_de   (post_de),
    .post_data (post_data),
    .overflow  (overflow),
    .cfg_err   (cfg_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] pix [$];
  logic [DW-1:0] got [FR];
  int            row_t [VD];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_img(int r, int c, int sx, int sy, int w, int h, bit cerr);
    return !cerr && r >= sy && r < sy + h && c >= sx && c < sx + w;
  endfunction

  task automatic pulse_fs(input int sx, input int sy, input int w, input int h,
                          input logic [DW-1:0] bg, input bit en_v);
    @(posedge clk); #1;
    en       = en_v;
    start_x  = XW'(sx);
    start_y  = YW'(sy);
    img_w    = XW'(w);
    img_h    = YW'(h);
    bg_color = bg;
    pre_vs   = 1'b1;
    pre_de   = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    pre_vs   = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " post_vs"},   post_vs,   0);
    check({tag, " post_de"},   post_de,   0);
    check({tag, " post_data"}, post_data, 0);
    check({tag, " overflow"},  overflow,  0);
    check({tag, " cfg_err"},   cfg_err,   0);
  endtask

  // One filled frame: feeder (flow-controlled by the model's level bound) and output monitor.
  task automatic run_frame(input string name, input int sx, input int sy, input int w, input int h,
                           input logic [DW-1:0] bg, input int late, input bit burst, input bit ramp);
    bit cerr;
    int total, pushed, consumed, nseen, vs_cnt, run_err, late_wait, r, c;
    bit mon_done, late_done, prev_de;
    logic [DW-1:0] e;

    cerr  = (sx + w > HD) || (sy + h > VD);
    total = burst ? 10 : w * h;
    pix.delete();
    for (int i = 0; i < total; i++) pix.push_back(ramp ? DW'(i) : DW'($urandom));
    for (int i = 0; i < FR; i++) got[i] = 'x;
    for (int i = 0; i < VD; i++) row_t[i] = 0;
    pushed = 0; consumed = 0; nseen = 0; vs_cnt = 0; run_err = 0; late_wait = 0;
    mon_done = 0; late_done = 0; prev_de = 0;

    pulse_fs(sx, sy, w, h, bg, 1'b1);

    fork
      begin
        for (int t = 0; t < 1500 && nseen < FR; t++) begin
          @(negedge clk);
          if (post_vs) vs_cnt++;
          if (post_de) begin
            got[nseen] = post_data;
            if (nseen % HD == 0) row_t[nseen / HD] = cyc;
            else if (!prev_de) run_err++;
            if (in_img(nseen / HD, nseen % HD, sx, sy, w, h, cerr)) consumed++;
            nseen++;
          end
          prev_de = post_de;
        end
        mon_done = 1;
      end
      begin
        while (!mon_done) begin
          pre_de = 1'b0;
          if (late > 0 && !late_done && pushed == late * w && pushed < total) begin
            if (consumed == pushed) begin
              late_wait++;
              if (late_wait >= 20) late_done = 1;
            end
          end else if (pushed < total && (burst || (pushed - consumed) < DEPTH) &&
                       (burst || $urandom_range(3) != 0)) begin
            pre_de   = 1'b1;
            pre_data = pix[pushed];
            pushed++;
          end
          @(posedge clk); #1;
        end
        pre_de = 1'b0;
      end
    join

    check({name, " frame_px"}, nseen, FR);
    for (int i = 0; i < FR; i++) begin
      r = i / HD;
      c = i % HD;
      e = in_img(r, c, sx, sy, w, h, cerr) ? pix[(r - sy) * w + (c - sx)] : bg;
      check($sformatf("%s px%0d", name, i), got[i], e);
    end
    check({name, " vs_len"},   vs_cnt,   VSL * LINE);
    check({name, " de_runs"},  run_err,  0);
    check({name, " cfg_err"},  cfg_err,  cerr);
    check({name, " overflow"}, overflow, burst);
    if (late > 0)
      check({name, " stall"}, (row_t[sy + late] - row_t[sy + late - 1]) > 32, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          bvs   [24];
    logic          bde   [24];
    logic [DW-1:0] bdata [24];
    bit found;
    int w, h;

    rst_n = 1'b0; en = 1'b0; start_x = '0; start_y = '0; img_w = '0; img_h = '0;
    bg_color = '0; pre_vs = 1'b0; pre_de = 1'b0; pre_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("idle");

    run_frame("pass",   0, 0, 8, 4, 24'hFFFFFF,   -1, 1'b0, 1'b1);
    run_frame("pos",    2, 1, 4, 2, 24'h123456,   -1, 1'b0, 1'b0);
    run_frame("stall",  0, 0, 8, 4, DW'($urandom), 2, 1'b0, 1'b0);
    run_frame("ovf",    1, 2, 4, 2, DW'($urandom), -1, 1'b1, 1'b0);
    run_frame("cfgerr", 6, 0, 4, 2, DW'($urandom), -1, 1'b0, 1'b0);

    for (int k = 0; k < 5; k++) begin
      w = $urandom_range(HD);
      h = $urandom_range(VD);
      run_frame($sformatf("rnd%0d", k), $urandom_range(HD - w), $urandom_range(VD - h),
                w, h, DW'($urandom), -1, 1'b0, 1'b0);
    end

    // Second frame start mid-ACT with stale pixels still buffered.
    pulse_fs(0, 0, 8, 4, 24'h0F0F0F, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pre_de = 1'b1; pre_data = 24'hABCD00 + DW'(i);
      @(posedge clk); #1;
    end
    pre_de = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = post_de;
    end
    check("refs reach_act", found, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      pre_de = 1'b1; pre_data = 24'hDEAD00 + DW'(i);
    end
    @(posedge clk); #1;
    pre_de = 1'b0;
    run_frame("refs", 0, 0, 8, 4, DW'($urandom), -1, 1'b0, 1'b0);

    // Asynchronous reset while pixels are being emitted.
    pulse_fs(0, 0, 8, 4, 24'h00FF00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pre_de = 1'b1; pre_data = 24'hBEEF00 + DW'(i);
      @(posedge clk); #1;
    end
    pre_de = 1'b0;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = post_de;
    end
    check("rst reach_act", found, 1);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_rel");
    run_frame("post_rst", 1, 1, 6, 3, DW'($urandom), -1, 1'b0, 1'b0);

    // Bypass: outputs are the inputs delayed by two cycles.
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      bvs[i]   = (i == 0) ? 1'b1 : 1'($urandom_range(1));
      bde[i]   = 1'($urandom_range(1));
      bdata[i] = DW'($urandom);
      en       = 1'b0;
      pre_vs   = bvs[i];
      pre_de   = bde[i];
      pre_data = bdata[i];
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("byp vs%0d", i),   post_vs,   bvs[i-2]);
        check($sformatf("byp de%0d", i),   post_de,   bde[i-2]);
        check($sformatf("byp data%0d", i), post_data, bdata[i-2]);
      end
    end
    pre_vs = 1'b0;
    pre_de = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
